// File: rtl/mcrc_modbus.sv
// rtl/mcrc_modbus.sv - byte-serial CRC-16/MODBUS accumulator
// One byte folded per cycle while ready is high; crc comes straight from the register.
module mcrc_modbus #(
    parameter logic [15:0] INIT = 16'hFFFF,
    parameter logic [15:0] POLY = 16'hA001
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ready,
    input  logic [7:0]  din,
    output logic [15:0] crc
);

    // Power-up value comes from the register initialiser; reset is still expected per frame.
    logic [15:0] c = INIT;
    logic [15:0] c_next;

    always_comb begin
        c_next = c ^ {8'h00, din};
        for (int i = 0; i < 8; i++) begin
            if (c_next[0]) begin
                c_next = (c_next >> 1) ^ POLY;
            end else begin
                c_next = c_next >> 1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            c <= INIT;
        end else if (ready) begin
            c <= c_next;
        end
    end

    assign crc = c;

endmodule

// File: tb/tb_mcrc_modbus.sv
// tb/tb_mcrc_modbus.sv - directed self-checking bench for mcrc_modbus
// Inputs change 1 time unit after the rising edge; outputs are checked there too.
module tb_mcrc_modbus;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        ready = 1'b0;
    logic [7:0]  din = 8'h00;
    logic [15:0] crc;

    int n_cmp = 0;
    int n_err = 0;

    mcrc_modbus dut (
        .clk   (clk),
        .reset (reset),
        .ready (ready),
        .din   (din),
        .crc   (crc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        ready = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic feed(input logic [7:0] b);
        ready = 1'b1;
        din = b;
        tick();
        ready = 1'b0;
    endtask

    task automatic idle(input int n);
        ready = 1'b0;
        for (int i = 0; i < n; i++) begin
            din = 8'($urandom);
            tick();
        end
    endtask

    // Reference: one message bit at a time, feedback is crc LSB xor data bit.
    function automatic logic [15:0] ref_byte(input logic [15:0] cur, input logic [7:0] b);
        logic [15:0] r;
        logic fb;
        r = cur;
        for (int i = 0; i < 8; i++) begin
            fb = r[0] ^ b[i];
            r = {1'b0, r[15:1]};
            if (fb) r = r ^ 16'hA001;
        end
        return r;
    endfunction

    initial begin
        logic [7:0]  frame [$];
        logic [15:0] model;
        logic [15:0] held;
        int          len;

        #1;
        check("powerup", crc, 16'hFFFF);

        do_reset();
        check("reset", crc, 16'hFFFF);

        // "123456789" back to back
        ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            din = 8'h31 + 8'(i);
            tick();
            if (i == 0) check("first_byte_31", crc, ref_byte(16'hFFFF, 8'h31));
        end
        ready = 1'b0;
        check("check_123456789", crc, 16'h4B37);

        // MODBUS read-holding-registers request with random idle gaps
        do_reset();
        frame = '{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01};
        foreach (frame[i]) begin
            feed(frame[i]);
            idle($urandom_range(0, 4));
        end
        check("modbus_frame", crc, 16'h0A84);
        feed(8'h84);
        idle($urandom_range(1, 3));
        feed(8'h0A);
        check("modbus_residue", crc, 16'h0000);

        do_reset();
        feed(8'h00);
        check("single_00", crc, 16'h40BF);
        do_reset();
        feed(8'hFF);
        check("single_ff", crc, 16'h00FF);

        // Reset collides with ready: byte dropped, INIT restored
        do_reset();
        feed(8'hA5);
        feed(8'h5A);
        feed(8'h3C);
        reset = 1'b1;
        ready = 1'b1;
        din = 8'h55;
        tick();
        reset = 1'b0;
        ready = 1'b0;
        check("reset_wins", crc, 16'hFFFF);
        ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            din = 8'h31 + 8'(i);
            tick();
        end
        ready = 1'b0;
        check("after_reset_123456789", crc, 16'h4B37);

        // Idle with din toggling must not disturb the register
        held = crc;
        idle(20);
        check("idle_hold", crc, held);
        check("idle_hold_value", crc, 16'h4B37);

        // Random frames against the bitwise reference, then residue
        for (int f = 0; f < 6; f++) begin
            do_reset();
            len = (f == 0) ? 1 : (f == 1) ? 256 : $urandom_range(1, 256);
            model = 16'hFFFF;
            ready = 1'b1;
            for (int i = 0; i < len; i++) begin
                din = 8'($urandom);
                model = ref_byte(model, din);
                tick();
                if ($urandom_range(0, 7) == 0) begin
                    ready = 1'b0;
                    idle($urandom_range(1, 3));
                    ready = 1'b1;
                end
            end
            ready = 1'b0;
            check($sformatf("rand_frame_%0d_len_%0d", f, len), crc, model);
            feed(model[7:0]);
            feed(model[15:8]);
            check($sformatf("rand_residue_%0d", f), crc, 16'h0000);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mcrc_modbus.md
# mcrc_modbus

Byte-serial CRC-16/MODBUS accumulator used by the MODBUS slave endpoint for both receive-frame checking and transmit-frame CRC generation. Each cycle that `ready` is asserted, the byte on `din` is folded into a registered 16-bit CRC. A synchronous `reset` restores the initial value. The `crc` output is the standard MODBUS CRC: low byte goes on the wire first, high byte second.

## Interface
Parameters:
- `INIT`, default 16'hFFFF: CRC value after reset.
- `POLY`, default 16'hA001: reflected generator polynomial, i.e. x^16+x^15+x^2+1 bit-reversed.

Ports:
- `clk`, input, 1: clock. All state changes occur on its rising edge.
- `reset`, input, 1: reset is synchronous and active-high. It loads `crc` with `INIT`.
- `ready`, input, 1: byte strobe. While high, `din` is absorbed on every rising edge.
- `din`, input, 8: data byte, processed LSB first.
- `crc`, output, 16: current CRC register, driven directly from the flop.

## Operation
- There is one 16-bit register, `c`, and `crc = c` at all times.
- At each rising edge, in priority order:
  - `reset` = 1: `c <= INIT`. This holds whether or not `ready` is high; reset always wins.
  - else `ready` = 1: `c <= F(c, din)`.
  - else: `c` holds its value.
- F(c, d), computed combinationally in one cycle:
  - Start with `t = c ^ {8'h00, d}`.
  - Repeat 8 times: if `t[0]` = 1, `t = (t >> 1) ^ POLY`; otherwise `t = t >> 1`. Use logical right shifts with zero fill.
  - The result is `t`. There is no final XOR and no output reflection.
- Checking a received frame:
  - Feed every byte except the two trailing CRC bytes.
  - Compare `crc` against {second CRC byte, first CRC byte}.
- Residue property: if the two CRC bytes are also fed (low byte first, then high byte), `crc` becomes 16'h0000. This is an equivalent frame-valid check.
- The power-up value of `c` is `INIT`, via register initialisation. Users still assert `reset` before each frame.
- There is no frame-length limit. The block has no state other than `c`.

## Timing
- Latency is one cycle: the result of the byte presented with `ready` at edge N appears on `crc` right after edge N.
- Back-to-back bytes are allowed. Holding `ready` high for K cycles absorbs K bytes, one `din` sample per edge, with no stall and no busy output.
- `din` is only sampled when `ready` = 1. It may change freely otherwise.
- Reset mid-frame discards all accumulated state, with no partial-byte memory.
- Reset and `ready` in the same cycle: the byte is dropped and `crc` becomes `INIT`. Callers drop reset one cycle before, or in the same cycle as, the first `ready`.
- Reset output value is `crc` = 16'hFFFF, taken from `INIT`.
- All inputs are synchronous to `clk`. The combinational path is an 8-step shift/XOR chain, registered at the output.

## Test plan
- Reset, then feed ASCII "123456789" (31..39 hex) with `ready` held high for 9 cycles -> `crc` = 16'h4B37 on the cycle after the last byte.
- Reset, then feed 01 03 00 00 00 01 with idle gaps of random length between bytes -> `crc` = 16'h0A84. Then feed 84 then 0A -> `crc` = 16'h0000.
- Reset, then a single byte 00 -> `crc` = 16'h40BF. Reset, then a single byte FF -> `crc` = 16'h00FF.
- Feed 3 bytes, assert `reset` for one cycle together with `ready` and `din` = 55, then release -> `crc` = 16'hFFFF, byte ignored. A following "123456789" gives 16'h4B37.
- Hold `ready` low for 20 cycles while `din` toggles randomly -> `crc` remains unchanged.
- Random frames of 1–256 bytes checked against a software CRC-16/MODBUS model. Each frame followed by its CRC (low, high) -> 16'h0000.
